pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. Each cycle it decides whether the PC and each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) capture, hold, or load a bubble. It drives the `hit` enable of EX/MEM and its siblings, detects load-use hazards, squashes wrong-path instructions on taken branches, and sequences instruction- and data-cache miss refills over a req/ack handshake. It also counts stall cycles for performance measurement.

## Interface
Parameters:
- `CNT_W`, 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on negedge, the same edge as the pipeline registers.
- `rstn`  in  1  asynchronous, active-low reset.
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in IF/ID.
- `ex_memread`  in  1  ID/EX holds a load.
- `ex_rt`  in  5  destination of that load.
- `mem_branch_taken`  in  1  EX/MEM branch control bit AND `oalu_zero`.
- `mem_access`  in  1  EX/MEM holds a load or store.
- `icache_hit`  in  1  fetch hit this cycle.
- `dcache_hit`  in  1  data hit; valid only when `mem_access` is high.
- `mem_ack`  in  1  refill complete. Single-cycle pulse.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  register capture enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each  load a bubble (all controls zero) instead of the input.
- `pc_src`  out  1  PC loads the branch target.
- `mem_req`  out  1  refill request.
- `mem_sel`  out  1  request type: 0 = instruction line, 1 = data line.
- `stall_cycles`  out  CNT_W  saturating stall counter.

## Operation
- FSM states: RUN, IMISS, DMISS. Reset state is RUN.
- Evaluation order in RUN (first match wins):
  1. **dmiss** (`mem_access & !dcache_hit`): all enables are 0 and `memwb_flush`=1. Next state is DMISS.
  2. **branch** (`mem_branch_taken`): `ifid_flush`, `idex_flush` and `exmem_flush` are 1; `pc_src`=1; all enables are 1.
  3. **imiss** (`!icache_hit`): all enables are 0. Next state is IMISS.
  4. **load-use** (`ex_memread & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt)`): `pc_en`=0, `ifid_en`=0, `idex_flush`=1. The other enables are 1.
  5. Otherwise all enables are 1 and all flushes are 0.
- In IMISS and DMISS:
  - All enables are 0. DMISS also holds `memwb_flush`=1.
  - `mem_req`=1. `mem_sel` = 1 in DMISS, 0 in IMISS.
  - `mem_ack` returns the FSM to RUN, and conditions are re-evaluated there. No abort path exists: a request stays up until acked.
- `mem_ack` while in RUN is ignored.
- Flush has priority over enable for the same register.
- `stall_cycles` increments on every edge where the FSM is not in RUN, or where load-use fires. It saturates at all-ones and is cleared only by reset.

## Timing
- Enables and flushes are combinational from state plus inputs. They are valid before the negedge that consumes them.
- `mem_req` and `mem_sel` are decoded from state only. They rise one cycle after miss detection.
- Miss penalty: 1 detection cycle + N request cycles, where `mem_ack` arrives on the Nth request cycle. The pipeline resumes in the cycle after ack.
- Load-use inserts exactly one bubble.
- A taken branch costs three squashed slots, with no stall.
- A dmiss and a taken branch cannot come from the same instruction. If both are asserted, dmiss wins and the branch is re-evaluated after the refill, because EX/MEM is frozen.
- Reset asserted mid-refill: immediate return to RUN, `mem_req`=0, counter cleared. Any refill in flight is abandoned.
- Reset values: state RUN, `mem_req` 0, `mem_sel` 0, `stall_cycles` 0. Combinational outputs follow the RUN decode of the current inputs.

## Structure
- Shared package `pipe_pkg`:
  - state encoding (RUN=0, IMISS=1, DMISS=2);
  - `MEMSEL_I` / `MEMSEL_D` constants;
  - register-number constant `REG_ZERO`.
- One natural sub-module: `load_use_detect`, purely combinational. It carries the equality and zero-register checks.

## Test plan
- **Reset:** rstn low during DMISS with `mem_ack`=0 → `mem_req`=0, state RUN, `stall_cycles`=0, all enables 1 with clean inputs.
- **Load-use:**
  - `ex_memread`=1, `ex_rt`=5, `id_rs`=5 → one cycle of `pc_en`=0, `ifid_en`=0, `idex_flush`=1, and `stall_cycles` +1.
  - Same stimulus with `ex_rt`=0 → no stall.
- **Data miss:** `mem_access`=1, `dcache_hit`=0, with `mem_ack` on the 3rd request cycle:
  - `mem_req`=1 and `mem_sel`=1 for 3 cycles;
  - all enables 0 and `memwb_flush`=1 for 4 cycles;
  - `stall_cycles`=3; RUN on the 5th cycle.
- **Branch vs. icache miss:** `mem_branch_taken`=1 with `icache_hit`=0 in the same cycle → three flushes, `pc_src`=1, no IMISS entry, `mem_req` stays 0.
- **Instruction miss:** `icache_hit`=0 with `mem_ack` 2 cycles later → `mem_sel`=0, whole pipeline frozen, no bubbles inserted.
- **Saturation:** hold DMISS with no ack for 65540 cycles → `stall_cycles`=16'hFFFF and it holds there.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and constants for the pipeline hazard controller
package pipe_pkg;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IMISS = 2'd1,
        DMISS = 2'd2
    } state_t;
    localparam logic       MEMSEL_I = 1'b0;
    localparam logic       MEMSEL_D = 1'b1;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an IF/ID instruction reading the destination of a load still in ID/EX
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);
    assign hazard = ex_memread && ex_rt != REG_ZERO && (ex_rt == id_rs || ex_rt == id_rt);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/refill sequencing for the five-stage pipeline
// State and counter update on the falling edge, alongside the pipeline registers.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_taken,
    input  logic             mem_access,
    input  logic             icache_hit,
    input  logic             dcache_hit,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             pc_src,
    output logic             mem_req,
    output logic             mem_sel,
    output logic [CNT_W-1:0] stall_cycles
);
    state_t     state, state_nxt;
    logic       lu, dmiss, lu_stall, in_miss;
    logic [4:0] en;
    logic [3:0] fl;

    load_use_detect u_lud (
        .ex_memread(ex_memread),
        .ex_rt     (ex_rt),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .hazard    (lu)
    );

    assign dmiss   = mem_access && !dcache_hit;
    assign in_miss = state == IMISS || state == DMISS;

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) state <= RUN;
        else       state <= state_nxt;
    end

    // Refills have no abort path; only an ack leaves a miss state.
    always_comb begin
        state_nxt = in_miss ? (mem_ack ? RUN : state)
                  : dmiss ? DMISS
                  : mem_branch_taken ? RUN
                  : !icache_hit ? IMISS : RUN;
    end

    always_comb begin
        en       = '1;
        fl       = '0;
        pc_src   = 1'b0;
        lu_stall = 1'b0;
        if (in_miss) begin
            en    = '0;
            fl[0] = state == DMISS;
        end else if (dmiss) begin
            en    = '0;
            fl[0] = 1'b1;
        end else if (mem_branch_taken) begin
            fl     = 4'b1110;
            pc_src = 1'b1;
        end else if (!icache_hit) begin
            en = '0;
        end else if (lu) begin
            en[4:3]  = 2'b00;
            fl[2]    = 1'b1;
            lu_stall = 1'b1;
        end
    end

    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en}      = en;
    assign {ifid_flush, idex_flush, exmem_flush, memwb_flush} = fl;
    assign mem_req = in_miss;
    assign mem_sel = state == DMISS ? MEMSEL_D : MEMSEL_I;

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn)                                        stall_cycles <= '0;
        else if ((in_miss || lu_stall) && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
    end
endmodule
